ib_read_ctrl: RTL and testbench
===============================

Name: ib_read_ctrl

Overview:
Read-side controller for the 5-entry router input buffer. It is the counterpart of the write-pointer logic.
- Tracks buffer occupancy from the writer's increment strobe.
- Owns the wrapping read pointer.
- Prefetches the head entry into an output register.
- Presents the head entry downstream on a valid/ready handshake.
- Flags full/empty for the writer and crossbar allocator, and flags overflow as an error.

Parameters:
DATA_WIDTH, 8, width of one buffer entry
DEPTH, 5, number of buffer entries; pointer wraps DEPTH-1 -> 0
PTR_WIDTH, 3, pointer/count width; must satisfy 2^PTR_WIDTH > DEPTH

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset
wr_inc_i  input  1  writer stored one entry this cycle (write-pointer advance strobe)
buf_data_i  input  DATA_WIDTH  buffer word at rdptr_addr_o (combinational read from storage)
rdptr_addr_o  output  PTR_WIDTH  current read pointer into buffer storage
rdptr_inc_o  output  1  pop strobe: head entry captured this cycle
out_valid_o  output  1  out_data_o holds a valid entry
out_data_o  output  DATA_WIDTH  registered head entry
out_ready_i  input  1  downstream accepts out_data_o this cycle
count_o  output  PTR_WIDTH  entries in storage, 0..DEPTH; excludes the output register
empty_o  output  1  count_o == 0
full_o  output  1  count_o == DEPTH
overflow_err_o  output  1  sticky: write attempted while full with no pop

Behaviour:
- Reset (reset low, asynchronous): rdptr_addr_o=0, count_o=0, out_valid_o=0, out_data_o=0, overflow_err_o=0, FSM=OUT_EMPTY. All outputs are held while reset is low. Reset mid-transfer discards all contents. There is no partial state after release.
- Define `accept = out_valid_o & out_ready_i`.
- Define `load = (count_o != 0) & (!out_valid_o | accept)`.
  - rdptr_inc_o = load. It is combinational from registered state and out_ready_i.
- On load:
  - out_data_o <= buf_data_i.
  - rdptr_addr_o <= (rdptr_addr_o == DEPTH-1) ? 0 : rdptr_addr_o + 1.
- Count update: count_next = count_o + wr_inc_i - load.
  - Simultaneous write and pop leaves the count unchanged.
- Overflow: wr_inc_i=1 while full_o=1 and load=0.
  - overflow_err_o sets and stays set until reset.
  - Count stays at DEPTH; the write is not counted.
  - When full with load=1 in the same cycle, the write is legal and the count stays DEPTH.
- No bypass: an entry written in cycle N is counted at the edge ending N and can be loaded in cycle N+1.
  - out_valid_o rises in cycle N+2, so minimum write-to-valid latency is 2 cycles.
- FSM, 2 states:
  - OUT_EMPTY: out_valid_o=0. load -> OUT_VALID; else stay.
  - OUT_VALID: out_valid_o=1.
    - accept & load -> stay, with new data back-to-back.
    - accept & !load -> OUT_EMPTY.
    - !accept -> stay.
- Hold rule: while out_valid_o & !out_ready_i, out_data_o and rdptr_addr_o are stable.
- Throughput: 1 entry/cycle sustained when out_ready_i is held high and the buffer is non-empty.
- Total storage is DEPTH+1 entries (buffer plus output register). full_o reflects the buffer only.
- out_ready_i while out_valid_o=0 is ignored.

Test Plan:
1. Reset then single write: wr_inc_i pulse in cycle 1, out_ready_i=1.
   - Required: count_o=1 in cycle 2; rdptr_inc_o=1 in cycle 2; out_valid_o=1 with the entry-0 word in cycle 3; rdptr_addr_o=1; count_o=0; empty_o=1.
2. Fill with out_ready_i=0: 6 write pulses.
   - Required: the first entry moves to the output register, then count_o climbs to 5 and full_o=1.
   - Required: a 7th write with no pop sets overflow_err_o=1 and count_o stays 5.
3. Wrap-around: stream 12 entries, values 0x10..0x1B, with out_ready_i=1.
   - Required: rdptr_addr_o sequence 0,1,2,3,4,0,1,... and the outputs appear in order 0x10..0x1B with no gaps once primed.
4. Backpressure: out_valid_o=1 holding 0xA5; drop out_ready_i for 3 cycles.
   - Required: out_data_o=0xA5 and rdptr_addr_o held; rdptr_inc_o=0; writes during the stall raise count_o.
5. Simultaneous write and pop at full (count_o=5, out_valid_o=1, out_ready_i=1, wr_inc_i=1).
   - Required: count_o stays 5, overflow_err_o stays 0, and the pointer advances by 1.
6. Asynchronous reset asserted mid-stream (count_o=3, out_valid_o=1).
   - Required: all outputs go to reset values immediately without a clock edge.
   - Required: after release, a new write yields first valid data 2 cycles later from address 0.

Source files
------------

// File: rtl/ib_read_ctrl.sv
// ib_read_ctrl: read side of the router input buffer.
// Tracks occupancy from the writer's increment strobe, owns the wrapping read pointer,
// prefetches the head entry into an output register and presents it on valid/ready.
//
// Ports:
//   clk             rising-edge clock
//   reset           asynchronous active-low reset
//   wr_inc_i        writer stored one entry this cycle
//   buf_data_i      storage word at rdptr_addr_o (combinational read)
//   rdptr_addr_o    read pointer into storage
//   rdptr_inc_o     pop strobe: head entry captured this cycle
//   out_valid_o     out_data_o holds a valid entry
//   out_data_o      registered head entry
//   out_ready_i     downstream accepts out_data_o this cycle
//   count_o         entries in storage (excludes the output register)
//   empty_o/full_o  storage occupancy flags
//   overflow_err_o  sticky: write while full with no pop
module ib_read_ctrl #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 5,
  parameter int unsigned PTR_WIDTH  = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_inc_i,
  input  logic [DATA_WIDTH-1:0] buf_data_i,
  output logic [PTR_WIDTH-1:0]  rdptr_addr_o,
  output logic                  rdptr_inc_o,
  output logic                  out_valid_o,
  output logic [DATA_WIDTH-1:0] out_data_o,
  input  logic                  out_ready_i,
  output logic [PTR_WIDTH-1:0]  count_o,
  output logic                  empty_o,
  output logic                  full_o,
  output logic                  overflow_err_o
);

  localparam logic [PTR_WIDTH-1:0] DepthVal = PTR_WIDTH'(DEPTH);
  localparam logic [PTR_WIDTH-1:0] LastPtr  = PTR_WIDTH'(DEPTH - 1);

  typedef enum logic [0:0] {OutEmpty, OutValid} state_e;

  state_e                state_q;
  logic [PTR_WIDTH-1:0]  rdptr_q, rdptr_d;
  logic [PTR_WIDTH-1:0]  count_q, count_d;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  ovf_q;
  logic                  accept, load, overflow;

  assign out_valid_o    = (state_q == OutValid);
  assign out_data_o     = data_q;
  assign rdptr_addr_o   = rdptr_q;
  assign count_o        = count_q;
  assign overflow_err_o = ovf_q;
  assign empty_o        = (count_q == '0);
  assign full_o         = (count_q == DepthVal);

  assign accept      = out_valid_o & out_ready_i;
  // Refill the output register whenever it is free or being drained this cycle.
  assign load        = !empty_o & (!out_valid_o | accept);
  assign rdptr_inc_o = load;
  // A write while full is only legal if a pop frees a slot in the same cycle.
  assign overflow    = wr_inc_i & full_o & !load;

  always_comb begin
    count_d = count_q;
    if (wr_inc_i && !load && !full_o) begin
      count_d = count_q + 1'b1;
    end else if (!wr_inc_i && load) begin
      count_d = count_q - 1'b1;
    end
  end

  always_comb begin
    rdptr_d = rdptr_q;
    if (load) begin
      rdptr_d = (rdptr_q == LastPtr) ? '0 : rdptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= OutEmpty;
      rdptr_q <= '0;
      count_q <= '0;
      data_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      rdptr_q <= rdptr_d;
      count_q <= count_d;
      if (overflow) begin
        ovf_q <= 1'b1;
      end
      if (load) begin
        data_q <= buf_data_i;
      end
      case (state_q)
        OutEmpty: begin
          if (load) begin
            state_q <= OutValid;
          end
        end
        OutValid: begin
          if (accept && !load) begin
            state_q <= OutEmpty;
          end
        end
        default: state_q <= OutEmpty;
      endcase
    end
  end

endmodule

// File: tb/tb_ib_read_ctrl.sv
// Self-checking bench for ib_read_ctrl. Emulates the buffer storage and writer, and keeps a
// queue-based reference of the buffer contents and the output register.
module tb_ib_read_ctrl;

  localparam int D = 5;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       wr_inc = 1'b0;
  logic [7:0] buf_data;
  logic [2:0] rdptr_addr;
  logic       rdptr_inc;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_ready = 1'b0;
  logic [2:0] count;
  logic       empty, full, overflow_err;

  int checks = 0;
  int failures = 0;

  // Storage and writer emulation
  logic [7:0] mem [D];
  int         wp = 0;
  logic [7:0] next_word = 8'h00;

  // Reference model: buffer contents as a queue, output register, pop counter, sticky error
  logic [7:0] mq[$];
  bit         mv = 0;
  logic [7:0] md = 8'h00;
  int         mrp = 0;
  bit         movf = 0;

  ib_read_ctrl dut (
    .clk            (clk),
    .reset          (reset),
    .wr_inc_i       (wr_inc),
    .buf_data_i     (buf_data),
    .rdptr_addr_o   (rdptr_addr),
    .rdptr_inc_o    (rdptr_inc),
    .out_valid_o    (out_valid),
    .out_data_o     (out_data),
    .out_ready_i    (out_ready),
    .count_o        (count),
    .empty_o        (empty),
    .full_o         (full),
    .overflow_err_o (overflow_err)
  );

  always #5 clk = ~clk;

  always_comb begin
    buf_data = 8'hxx;
    if (rdptr_addr < 3'(D)) buf_data = mem[rdptr_addr];
  end

  function automatic bit mload();
    return (mq.size() != 0) && (!mv || out_ready);
  endfunction

  task automatic model_reset();
    mq.delete();
    mv = 0; md = 8'h00; mrp = 0; movf = 0; wp = 0;
  endtask

  // Called at a negedge: drive inputs and let combinational outputs settle.
  task automatic set_in(input bit wr, input bit rdy, input logic [7:0] w);
    wr_inc = wr; out_ready = rdy; next_word = w;
    #1;
  endtask

  // Advance one clock edge, updating storage and model after the DUT has sampled.
  task automatic tick();
    bit ld, acc, full_before;
    ld = mload();
    acc = mv && out_ready;
    full_before = (mq.size() == D);
    @(posedge clk);
    #1;
    if (ld) begin
      md = mq.pop_front(); mv = 1; mrp = (mrp + 1) % D;
    end else if (acc) begin
      mv = 0;
    end
    if (wr_inc) begin
      if (full_before && !ld) movf = 1;
      else begin
        mq.push_back(next_word); mem[wp] = next_word; wp = (wp + 1) % D;
      end
    end
    @(negedge clk);
  endtask

  task automatic apply_reset();
    reset = 1'b0; wr_inc = 1'b0; out_ready = 1'b0; next_word = 8'h00;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if ({rdptr_addr, count, out_valid, out_data, overflow_err, empty, full, rdptr_inc} !==
        {3'd0, 3'd0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL reset_state: addr=%0d cnt=%0d v=%0b d=%h ovf=%0b e=%0b f=%0b inc=%0b",
               rdptr_addr, count, out_valid, out_data, overflow_err, empty, full, rdptr_inc);
    end
  endtask

  task automatic test_single_write();
    apply_reset();
    set_in(1, 1, 8'h3C); tick();
    set_in(0, 1, 8'h00);
    checks++;
    if (count !== 3'd1 || rdptr_inc !== 1'b1) begin
      failures++;
      $display("FAIL single_cycle2: cnt=%0d inc=%0b expected cnt=1 inc=1", count, rdptr_inc);
    end
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'h3C || rdptr_addr !== 3'd1 || count !== 3'd0 ||
        empty !== 1'b1) begin
      failures++;
      $display("FAIL single_cycle3: v=%0b d=%h addr=%0d cnt=%0d e=%0b expected 1 3c 1 0 1",
               out_valid, out_data, rdptr_addr, count, empty);
    end
  endtask

  task automatic test_fill_overflow();
    int exp_cnt [6] = '{1, 1, 2, 3, 4, 5};
    apply_reset();
    for (int i = 0; i < 6; i++) begin
      set_in(1, 0, 8'(8'h40 + i)); tick();
      checks++;
      if (count !== 3'(exp_cnt[i]) || count !== 3'(mq.size())) begin
        failures++;
        $display("FAIL fill_count[%0d]: got %0d expected %0d", i, count, exp_cnt[i]);
      end
    end
    checks++;
    if (full !== 1'b1 || out_valid !== 1'b1 || out_data !== 8'h40 || overflow_err !== 1'b0) begin
      failures++;
      $display("FAIL fill_full: f=%0b v=%0b d=%h ovf=%0b expected 1 1 40 0",
               full, out_valid, out_data, overflow_err);
    end
    set_in(1, 0, 8'hEE); tick();
    checks++;
    if (overflow_err !== 1'b1 || count !== 3'd5) begin
      failures++;
      $display("FAIL overflow: ovf=%0b cnt=%0d expected 1 5", overflow_err, count);
    end
    set_in(0, 0, 8'h00); tick();
    checks++;
    if (overflow_err !== 1'b1) begin
      failures++;
      $display("FAIL overflow_sticky: ovf=%0b expected 1", overflow_err);
    end
  endtask

  task automatic test_wrap();
    int nout = 0;
    int npop = 0;
    bit primed = 0;
    apply_reset();
    for (int c = 0; c < 20 && nout < 12; c++) begin
      set_in(c < 12, 1, 8'(8'h10 + c));
      if (rdptr_inc === 1'b1) begin
        checks++;
        if (rdptr_addr !== 3'(npop % D)) begin
          failures++;
          $display("FAIL wrap_addr[%0d]: got %0d expected %0d", npop, rdptr_addr, npop % D);
        end
        npop++;
      end
      tick();
      if (out_valid === 1'b1) begin
        primed = 1;
        checks++;
        if (out_data !== 8'(8'h10 + nout)) begin
          failures++;
          $display("FAIL wrap_data[%0d]: got %h expected %h", nout, out_data, 8'(8'h10 + nout));
        end
        nout++;
      end else if (primed) begin
        checks++;
        failures++;
        $display("FAIL wrap_gap: out_valid=0 after %0d outputs, expected 1", nout);
      end
    end
    checks++;
    if (nout != 12) begin
      failures++;
      $display("FAIL wrap_total: got %0d outputs expected 12", nout);
    end
  endtask

  task automatic test_backpressure();
    logic [2:0] addr0;
    apply_reset();
    set_in(1, 0, 8'hA5); tick();
    set_in(1, 0, 8'h5A); tick();
    addr0 = rdptr_addr;
    for (int i = 0; i < 3; i++) begin
      set_in(1, 0, 8'(8'h60 + i));
      checks++;
      if (rdptr_inc !== 1'b0) begin
        failures++;
        $display("FAIL bp_inc[%0d]: got %0b expected 0", i, rdptr_inc);
      end
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_data !== 8'hA5 || rdptr_addr !== addr0 ||
          count !== 3'(2 + i)) begin
        failures++;
        $display("FAIL bp_hold[%0d]: v=%0b d=%h addr=%0d cnt=%0d expected 1 a5 %0d %0d",
                 i, out_valid, out_data, rdptr_addr, count, addr0, 2 + i);
      end
    end
    set_in(0, 1, 8'h00); tick();
    checks++;
    if (out_data !== 8'h5A || rdptr_addr !== 3'(addr0 + 1)) begin
      failures++;
      $display("FAIL bp_release: d=%h addr=%0d expected 5a %0d", out_data, rdptr_addr, addr0 + 1);
    end
  endtask

  task automatic test_full_simul();
    apply_reset();
    for (int i = 0; i < 6; i++) begin
      set_in(1, 0, 8'(8'h70 + i)); tick();
    end
    set_in(1, 1, 8'h7F);
    checks++;
    if (rdptr_inc !== 1'b1 || count !== 3'd5 || rdptr_addr !== 3'd1) begin
      failures++;
      $display("FAIL simul_pre: inc=%0b cnt=%0d addr=%0d expected 1 5 1",
               rdptr_inc, count, rdptr_addr);
    end
    tick();
    checks++;
    if (count !== 3'd5 || overflow_err !== 1'b0 || rdptr_addr !== 3'd2 || out_data !== 8'h71) begin
      failures++;
      $display("FAIL simul_post: cnt=%0d ovf=%0b addr=%0d d=%h expected 5 0 2 71",
               count, overflow_err, rdptr_addr, out_data);
    end
  endtask

  task automatic test_async_reset();
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      set_in(1, 0, 8'(8'h20 + i)); tick();
    end
    checks++;
    if (count !== 3'd3 || out_valid !== 1'b1) begin
      failures++;
      $display("FAIL areset_setup: cnt=%0d v=%0b expected 3 1", count, out_valid);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({rdptr_addr, count, out_valid, out_data, overflow_err, empty, rdptr_inc} !==
        {3'd0, 3'd0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL areset_immediate: addr=%0d cnt=%0d v=%0b d=%h ovf=%0b e=%0b inc=%0b",
               rdptr_addr, count, out_valid, out_data, overflow_err, empty, rdptr_inc);
    end
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    set_in(1, 1, 8'h5C); tick();
    set_in(0, 1, 8'h00);
    checks++;
    if (rdptr_inc !== 1'b1 || rdptr_addr !== 3'd0 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL areset_reload: inc=%0b addr=%0d v=%0b expected 1 0 0",
               rdptr_inc, rdptr_addr, out_valid);
    end
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'h5C) begin
      failures++;
      $display("FAIL areset_first: v=%0b d=%h expected 1 5c", out_valid, out_data);
    end
  endtask

  task automatic test_random();
    apply_reset();
    for (int c = 0; c < 400; c++) begin
      // Phase-varying write pressure so the buffer both fills and drains
      set_in(($urandom_range(0, 99) < ((c / 50) % 2 ? 80 : 35)), ($urandom_range(0, 1) == 1),
             8'($urandom));
      checks++;
      if (rdptr_inc !== mload()) begin
        failures++;
        $display("FAIL rand_inc[%0d]: got %0b expected %0b", c, rdptr_inc, mload());
      end
      tick();
      checks++;
      if (count !== 3'(mq.size()) || empty !== (mq.size() == 0) || full !== (mq.size() == D) ||
          out_valid !== mv || out_data !== md || rdptr_addr !== 3'(mrp) ||
          overflow_err !== movf) begin
        failures++;
        $display("FAIL rand_state[%0d]: cnt=%0d/%0d v=%0b/%0b d=%h/%h addr=%0d/%0d ovf=%0b/%0b",
                 c, count, mq.size(), out_valid, mv, out_data, md, rdptr_addr, mrp,
                 overflow_err, movf);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < D; i++) mem[i] = 8'h00;
    test_reset();
    test_single_write();
    test_fill_overflow();
    test_wrap();
    test_backpressure();
    test_full_simul();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
